// File: rtl/alu_bypass_controller.sv
// Issue and operand-select controller for the EX-stage ALU: tracks the last issued rd and one
// in-flight load, drives ALU mux selects and stalls decode. EX->EX forwarding needs ALU_BYPASS_EN.
module alu_bypass_controller #(
    parameter int unsigned LOAD_LATENCY      = 2,
    // Reset value of stall_cycles; non-zero only to exercise saturation.
    parameter logic [31:0] STALL_RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_op1_pc,
    input  logic        id_op2_imm,
    input  logic [4:0]  id_rd,
    input  logic        id_writes_rd,
    input  logic        id_is_load,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic [1:0]  ex_mux1_select,
    output logic [1:0]  ex_mux2_select,
    output logic        load_use_stall,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] SelReg = 2'b00;
    localparam logic [1:0] SelFwd = 2'b01;
    localparam logic [1:0] SelPcImm = 2'b10;

    typedef enum logic {StRun, StLoadPending} state_e;

    logic        ex_valid_q, ex_valid_d;
    logic [1:0]  mux1_q, mux1_d, mux2_q, mux2_d;
    logic [4:0]  last_rd_q, last_rd_d;
    logic        last_writes_q, last_writes_d;
    logic        last_is_load_q, last_is_load_d;
    logic [4:0]  load_rd_q, load_rd_d;
    logic [2:0]  load_cnt_q, load_cnt_d;
    logic [31:0] stall_q, stall_d;

    state_e     state;
    logic       hit1, hit2, fwd1, fwd2;
    logic       load_haz, load_block, fwd_stall, issue;
    logic [1:0] sel1, sel2;
    logic [2:0] cnt_dec;

    assign state = (load_cnt_q != 3'd0) ? StLoadPending : StRun;

    assign hit1 = id_uses_rs1 && (id_rs1 != 5'd0);
    assign hit2 = id_uses_rs2 && (id_rs2 != 5'd0);
    assign fwd1 = id_uses_rs1 && last_writes_q && !last_is_load_q && (last_rd_q != 5'd0)
                  && (id_rs1 == last_rd_q);
    assign fwd2 = id_uses_rs2 && last_writes_q && !last_is_load_q && (last_rd_q != 5'd0)
                  && (id_rs2 == last_rd_q);

    assign load_haz   = (state == StLoadPending)
                        && ((hit1 && (id_rs1 == load_rd_q)) || (hit2 && (id_rs2 == load_rd_q)));
    assign load_block = (state == StLoadPending) && id_is_load;

`ifdef ALU_BYPASS_EN
    assign fwd_stall = 1'b0;
    assign sel1 = id_op1_pc  ? SelPcImm : (fwd1 ? SelFwd : SelReg);
    assign sel2 = id_op2_imm ? SelPcImm : (fwd2 ? SelFwd : SelReg);
`else
    // Without forwarding, wait one bubble so the producer's result reaches the register bus.
    assign fwd_stall = (fwd1 && !id_op1_pc) || (fwd2 && !id_op2_imm);
    assign sel1 = id_op1_pc  ? SelPcImm : SelReg;
    assign sel2 = id_op2_imm ? SelPcImm : SelReg;
`endif

    assign id_ready = !reset && !flush && ex_ready && !load_haz && !load_block && !fwd_stall;
    assign issue    = id_valid && id_ready;
    assign load_use_stall = !reset && id_valid && (load_haz || load_block);
    assign cnt_dec  = (load_cnt_q != 3'd0) ? load_cnt_q - 3'd1 : 3'd0;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        mux1_d         = mux1_q;
        mux2_d         = mux2_q;
        last_rd_d      = last_rd_q;
        last_writes_d  = last_writes_q;
        last_is_load_d = last_is_load_q;
        load_rd_d      = load_rd_q;
        load_cnt_d     = load_cnt_q;
        stall_d        = stall_q;

        if (id_valid && !id_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end

        if (flush) begin
            ex_valid_d    = 1'b0;
            mux1_d        = SelReg;
            mux2_d        = SelReg;
            last_writes_d = 1'b0;
            load_cnt_d    = cnt_dec;
        end else if (ex_ready) begin
            if (issue) begin
                ex_valid_d     = 1'b1;
                mux1_d         = sel1;
                mux2_d         = sel2;
                last_rd_d      = id_rd;
                last_writes_d  = id_writes_rd;
                last_is_load_d = id_is_load;
                if (id_is_load) begin
                    load_rd_d  = id_rd;
                    load_cnt_d = 3'(LOAD_LATENCY);
                end else begin
                    load_cnt_d = cnt_dec;
                end
            end else begin
                ex_valid_d    = 1'b0;
                mux1_d        = SelReg;
                mux2_d        = SelReg;
                last_writes_d = 1'b0;
                load_cnt_d    = cnt_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            mux1_q         <= SelReg;
            mux2_q         <= SelReg;
            last_rd_q      <= 5'd0;
            last_writes_q  <= 1'b0;
            last_is_load_q <= 1'b0;
            load_rd_q      <= 5'd0;
            load_cnt_q     <= 3'd0;
            stall_q        <= STALL_RESET_VALUE;
        end else begin
            ex_valid_q     <= ex_valid_d;
            mux1_q         <= mux1_d;
            mux2_q         <= mux2_d;
            last_rd_q      <= last_rd_d;
            last_writes_q  <= last_writes_d;
            last_is_load_q <= last_is_load_d;
            load_rd_q      <= load_rd_d;
            load_cnt_q     <= load_cnt_d;
            stall_q        <= stall_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_mux1_select = mux1_q;
    assign ex_mux2_select = mux2_q;
    assign stall_cycles   = stall_q;

endmodule

// File: doc/alu_bypass_controller.md
# alu_bypass_controller

Issue and operand-select controller for the execution-stage ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and tracks the destination register of the previously issued instruction and of any in-flight load. It drives the ALU operand multiplexer selects (`00` register bus, `01` forwarded result, `10` PC or immediate), and stalls decode on load-use or non-forwardable hazards. It sits between Instruction_Decoder/Control_Unit and the ALU pipeline register.

## Interface
- `LOAD_LATENCY`, default 2: cycles after a load's issue cycle before its data is readable on the register-file bus. Legal range 1–7.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  decoded instruction present.
- `id_ready`  out  1  combinational; instruction issues at an edge where `id_valid && id_ready`.
- `id_rs1`, `id_rs2`  in  5 each  source register indices.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  operand actually reads the register.
- `id_op1_pc`  in  1  operand_1 is PC.
- `id_op2_imm`  in  1  operand_2 is immediate.
- `id_rd`  in  5  destination register.
- `id_writes_rd`  in  1  instruction writes rd.
- `id_is_load`  in  1  instruction is a load.
- `ex_ready`  in  1  execution stage can advance; 0 freezes the controller.
- `flush`  in  1  kill the younger instruction (branch/jump redirect).
- `ex_valid`  out  1  registered; EX holds a valid instruction.
- `ex_mux1_select`, `ex_mux2_select`  out  2 each  registered ALU mux selects.
- `load_use_stall`  out  1  combinational; stall cause is a pending load.
- `stall_cycles`  out  32  registered saturating count of stalled cycles.

## Operation
- Tracking registers: `last_rd`, `last_writes`, `last_is_load`, `load_rd`, `load_cnt[2:0]`.
- State is `RUN` when `load_cnt == 0`, otherwise `LOAD_PENDING`.
- Hit on rsN: `id_uses_rsN && rsN != 0`.
- Load hazard: in `LOAD_PENDING` and a hit with `rsN == load_rd`.
- Issue-time load block: `id_is_load` while in `LOAD_PENDING` stalls. At most one load is tracked at a time.
- Forward hit: `last_writes && !last_is_load && last_rd != 0 && rsN == last_rd`.
- `id_ready = !reset && !flush && ex_ready && !load hazard && !issue-time load block` (plus the non-bypass rule under Configuration).
- Mux select priority, per operand: PC/immediate gives `10`; else forward hit gives `01`; else `00`.
- On issue: the selects are registered, `ex_valid` goes to 1, and `last_*` take the id fields.
  - If `id_is_load`: `load_rd` takes `id_rd` and `load_cnt` takes `LOAD_LATENCY`.
- No issue while `ex_ready = 1`: `ex_valid` and both selects go to 0, and `last_writes` goes to 0. This is a bubble; the previous result then reads correctly from the register bus.
- `load_cnt` decrements by 1 on every cycle with `ex_ready = 1`, saturating at 0. A load issuing while the count is 0 reloads it; there is no simultaneous decrement.
- `ex_ready = 0` and no `flush`: all registers hold.
- `flush` (overrides `ex_ready`): `ex_valid` and selects go to 0, `last_writes` goes to 0, no issue occurs. Load tracking continues to decrement.
- `stall_cycles` increments when `id_valid && !id_ready` and `reset` is 0. It saturates at `0xFFFFFFFF`.

## Timing
- Reset values: `ex_valid = 0`, selects `00`, `load_cnt = 0`, `last_writes = 0`, `stall_cycles = 0`. `id_ready = 0` while `reset` is high.
- Issue latency: 1 cycle. The selects are valid in the cycle after the issuing edge, aligned with the EX operands.
- Back-to-back dependent ALU ops: 0 stall cycles (forwarded).
- Load followed immediately by a dependent instruction: `LOAD_LATENCY` stall cycles. The dependent then issues with `00`.
- Reset mid-stall clears all tracking. The instruction still presented after reset issues with no hazard.

## Configuration
- Macro `ALU_BYPASS_EN`.
- **Defined:** EX→EX forwarding as described.
- **Undefined:** select `01` is never produced. A forward hit instead deasserts `id_ready` for one cycle. The resulting bubble clears `last_writes`, and the instruction then issues with `00`.

## Test plan
- **Reset:** hold `reset` 3 cycles with `id_valid = 1` → `id_ready = 0`, `ex_valid = 0`, selects `00`, `stall_cycles = 0`.
- **ALU forwarding:** ADD x5 ← x1,x2 then SUB x6 ← x5,x5 on consecutive cycles → SUB issues with no stall, `ex_mux1_select = ex_mux2_select = 01`. Without `ALU_BYPASS_EN` → one stall cycle, then `00/00`, `stall_cycles = 1`.
- **Load-use:** load x7 with `LOAD_LATENCY = 2`, then ADDI x8 ← x7 with imm → 2 stall cycles with `load_use_stall = 1`, then issue with mux1 `00`, mux2 `10`.
- **x0:** ADD x0 then ADD x3 ← x0,x0 → selects `00/00`, no stall.
- **Flush + freeze:** `ex_ready = 0` for 3 cycles → selects and `ex_valid` hold, `load_cnt` frozen. `flush` asserted together with `ex_ready = 0` → `ex_valid = 0` next cycle, and the following dependent op issues with `00`.
- **Saturation:** preload `stall_cycles` to `0xFFFFFFFE` and stall 3 cycles → counter reads `0xFFFFFFFF`.
